// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
// Serial front end of the SPI configuration port. The SPI pins are
// oversampled in the clk domain (mode 0). 16-bit write frames are
// deserialized into a 4-bit address and a 12-bit data word, which are
// presented with a one-cycle is_ready strobe. During every frame a status
// word {4'hA, status_i} is shifted out on MISO.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   spi_sclk         SPI clock (async, idle low)
//   spi_cs_n         chip select, active low (async)
//   spi_mosi         serial data in, MSB first (async)
//   status_i[11:0]   status word captured at frame start for readback
//   spi_miso         serial data out
//   spi_address[3:0] address of the last valid frame
//   spi_data[11:0]   data of the last valid frame
//   is_ready         one-cycle pulse when a valid frame is presented
//   frame_error_o    one-cycle pulse when a frame is discarded
// -----------------------------------------------------------------------------
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic [11:0] status_i,
  output logic        spi_miso,
  output logic [3:0]  spi_address,
  output logic [11:0] spi_data,
  output logic        is_ready,
  output logic        frame_error_o
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    OVERRUN
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic [15:0]            rx_q;
  logic [15:0]            tx_q;
  logic [4:0]             cnt_q;
  logic [3:0]             addr_q;
  logic [11:0]            data_q;
  logic                   ready_q;
  logic                   err_q;
  logic                   miso_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic primed;

  // Synchronizers plus one extra stage on SCLK/CS for edge detection.
  // prime_q fills with ones after reset; until it is full the sync chains
  // still hold their reset values rather than real pin samples.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      prime_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign primed    = prime_q[SYNC_STAGES];

  // Frame FSM; all outputs are registered here.
  // NOTE: the shift/data registers are small and reset with everything else,
  // so an async reset clears any in-flight frame completely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
      rx_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        WAIT_IDLE: begin
          miso_q <= 1'b0;
          // Waiting for real (primed) CS high means a reset taken with CS low
          // never starts a partial frame.
          if (primed && cs_s) state_q <= IDLE;
        end
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            cnt_q   <= '0;
            tx_q    <= {4'hA, status_i};
            miso_q  <= 1'b1;  // MSB of the 4'hA tag
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            if (cnt_q == 5'd16) begin
              addr_q  <= rx_q[15:12];
              data_q  <= rx_q[11:0];
              ready_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_q <= {rx_q[14:0], mosi_s};
            if (cnt_q == 5'd16) begin
              cnt_q   <= 5'd17;
              miso_q  <= 1'b0;
              state_q <= OVERRUN;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end else if (sclk_fall) begin
            tx_q   <= {tx_q[14:0], 1'b0};
            miso_q <= tx_q[14];
          end
        end
        OVERRUN: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign spi_miso      = miso_q;
  assign spi_address   = addr_q;
  assign spi_data      = data_q;
  assign is_ready      = ready_q;
  assign frame_error_o = err_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
// Directed bench for spi_frame_receiver. Each frame pushes its expected
// outcome (ready or error, plus the outputs expected afterwards) to a
// scoreboard queue; a monitor pops and compares whenever a strobe appears.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

  typedef struct {
    bit         is_err;
    logic [3:0] addr;
    logic [11:0] data;
  } sb_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [11:0] status_i;
  logic        spi_miso;
  logic [3:0]  spi_address;
  logic [11:0] spi_data;
  logic        is_ready;
  logic        frame_error_o;

  int  vectors = 0;
  int  miscompares = 0;
  sb_e sb_q[$];

  spi_frame_receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .status_i     (status_i),
    .spi_miso     (spi_miso),
    .spi_address  (spi_address),
    .spi_data     (spi_data),
    .is_ready     (is_ready),
    .frame_error_o(frame_error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input bit is_err, input logic [3:0] a, input logic [11:0] d);
    sb_e e;
    e.is_err = is_err;
    e.addr   = a;
    e.data   = d;
    sb_q.push_back(e);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(8);
  endtask

  // Shifts n bits of val MSB first; SCLK low/high 4 clk each. MISO is
  // captured just before each rising edge, as the host would.
  task automatic send_bits(input logic [31:0] val, input int n, output logic [31:0] miso_w);
    miso_w = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      tick(4);
      miso_w   = {miso_w[30:0], spi_miso};
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  // Raises CS after the hold time; optionally checks the strobe pattern
  // {is_ready, frame_error_o} exactly SYNC_STAGES+1 cycles later.
  task automatic cs_high(input bit chk, input logic [1:0] exp_strobe, input int gap);
    tick(4);
    spi_cs_n = 1'b1;
    if (chk) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("early_strobe", {30'd0, is_ready, frame_error_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("strobe_latency", {30'd0, is_ready, frame_error_o}, {30'd0, exp_strobe});
      #2;
    end
    tick(gap);
  endtask

  // Scoreboard monitor, sampling on the falling clk edge.
  always @(negedge clk) begin
    if (rst_n && (is_ready || frame_error_o)) begin
      check("strobe_exclusive", {31'd0, is_ready & frame_error_o}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, is_ready, frame_error_o}, 32'd0);
      end else begin
        sb_e e;
        e = sb_q.pop_front();
        check("strobe_kind", {31'd0, frame_error_o}, {31'd0, e.is_err});
        check("sb_addr", {28'd0, spi_address}, {28'd0, e.addr});
        check("sb_data", {20'd0, spi_data}, {20'd0, e.data});
      end
    end
  end

  logic [31:0] mw, mw2;

  initial begin
    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    status_i = 12'h000;
    tick(3);
    check("rst_addr", {28'd0, spi_address}, 32'd0);
    check("rst_data", {20'd0, spi_data}, 32'd0);
    check("rst_ready", {31'd0, is_ready}, 32'd0);
    check("rst_err", {31'd0, frame_error_o}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    rst_n = 1'b1;
    tick(10);

    // Valid write 0xE032; readback of zero status gives 0xA000.
    push(1'b0, 4'hE, 12'h032);
    cs_low();
    send_bits(32'hE032, 16, mw);
    cs_high(1'b1, 2'b10, 8);
    check("valid_addr", {28'd0, spi_address}, 32'hE);
    check("valid_data", {20'd0, spi_data}, 32'h032);
    check("miso_zero_status", mw, 32'hA000);

    // 15-bit frame: discarded, outputs held.
    push(1'b1, 4'hE, 12'h032);
    cs_low();
    send_bits(32'h1234, 15, mw);
    cs_high(1'b1, 2'b01, 8);

    // 20-bit frame: overrun, discarded at CS rise; MISO is 0 after 16 bits.
    push(1'b1, 4'hE, 12'h032);
    cs_low();
    send_bits(32'hABCDE, 20, mw);
    cs_high(1'b1, 2'b01, 8);
    check("overrun_miso_tail", mw & 32'hF, 32'd0);
    check("overrun_data", {20'd0, spi_data}, 32'h032);

    // Readback: status 0x5C3 at CS fall, changed after 3 bits.
    status_i = 12'h5C3;
    push(1'b0, 4'h1, 12'h001);
    cs_low();
    send_bits(32'h0, 3, mw);
    status_i = 12'hFFF;
    send_bits(32'h1001, 13, mw2);
    cs_high(1'b1, 2'b10, 8);
    check("readback", (mw << 13) | mw2, 32'hA5C3);
    check("idle_miso", {31'd0, spi_miso}, 32'd0);

    // Back-to-back frames with 2-cycle CS-high gap.
    push(1'b0, 4'hC, 12'h010);
    push(1'b0, 4'hD, 12'h001);
    cs_low();
    send_bits(32'hC010, 16, mw);
    cs_high(1'b0, 2'b00, 2);
    cs_low();
    send_bits(32'hD001, 16, mw);
    cs_high(1'b0, 2'b00, 12);
    check("b2b_addr", {28'd0, spi_address}, 32'hD);
    check("b2b_data", {20'd0, spi_data}, 32'h001);
    check("b2b_drained", sb_q.size(), 32'd0);

    // Reset after 8 bits with CS low; remaining bits must be ignored.
    cs_low();
    send_bits(32'h12, 8, mw);
    rst_n = 1'b0;
    tick(2);
    check("midrst_addr", {28'd0, spi_address}, 32'd0);
    check("midrst_data", {20'd0, spi_data}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    send_bits(32'h34, 8, mw);
    cs_high(1'b1, 2'b00, 8);
    push(1'b0, 4'h1, 12'h001);
    cs_low();
    send_bits(32'h1001, 16, mw);
    cs_high(1'b1, 2'b10, 8);
    check("post_rst_addr", {28'd0, spi_address}, 32'h1);
    check("post_rst_data", {20'd0, spi_data}, 32'h001);

    // CS glitch with no SCLK edges.
    push(1'b1, 4'h1, 12'h001);
    spi_cs_n = 1'b0;
    tick(4);
    cs_high(1'b1, 2'b01, 8);

    tick(20);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
